// File: rtl/vec_pkg.sv
// Shared vector widths, register-file geometry and write-back FSM states.
package vec_pkg;

  localparam int LANES  = 16;
  localparam int LANE_W = 32;
  localparam int VW     = LANES * LANE_W;
  localparam int NREGS  = 4;
  localparam int ADDR_W = $clog2(NREGS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } wb_state_t;

endpackage

// File: rtl/alu_writeback_seq_if.sv
// ALU-result handshake bus: the ALU drives the master side, the write-back stage the slave side.
interface alu_writeback_seq_if;

  logic                        in_valid;
  logic                        in_ready;
  logic                        in_mul;
  logic [vec_pkg::ADDR_W-1:0]  in_dst;
  logic [vec_pkg::VW-1:0]      s0;
  logic [vec_pkg::VW-1:0]      s1;

  modport master (output in_valid, output in_mul, output in_dst, output s0, output s1,
                  input  in_ready);
  modport slave  (input  in_valid, input  in_mul, input  in_dst, input  s0, input  s1,
                  output in_ready);

endinterface

// File: rtl/alu_writeback_seq_ovf.sv
// wb_ovf_detect: per-lane flag set when the high half is not the sign extension of the low half.
module wb_ovf_detect
  import vec_pkg::*;
(
  input  logic [VW-1:0]    lo,
  input  logic [VW-1:0]    hi,
  output logic [LANES-1:0] mask
);

  always_comb begin
    mask = '0;
    for (int i = 0; i < LANES; i++) begin
      mask[i] = (hi[i*LANE_W +: LANE_W] != {LANE_W{lo[i*LANE_W + LANE_W - 1]}});
    end
  end

endmodule

// File: rtl/alu_writeback_seq.sv
// Latches one ALU result and writes it to the vector register file in one (add) or two (multiply) beats.
// Optional build macro WB_OVF_FLAG_EN adds the registered per-lane ovf_mask output.
module alu_writeback_seq
  import vec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  alu_writeback_seq_if.slave bus,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [VW-1:0]     wr_data,
  output logic              done,
  output logic              busy
`ifdef WB_OVF_FLAG_EN
  ,
  output logic [LANES-1:0]  ovf_mask
`endif
);

  wb_state_t         state;
  logic [VW-1:0]     lo_q;
  logic [VW-1:0]     hi_q;
  logic              mul_q;
  logic [ADDR_W-1:0] dst_q;
  logic              accept;

  // Ready in IDLE and on any final beat, so a new result overlaps the last write.
  assign bus.in_ready = (state == IDLE) || (state == WR_LO && !mul_q) || (state == WR_HI);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      lo_q  <= '0;
      hi_q  <= '0;
      mul_q <= 1'b0;
      dst_q <= '0;
    end else begin
      if (accept) begin
        lo_q  <= bus.s0;
        hi_q  <= bus.s1;
        mul_q <= bus.in_mul;
        dst_q <= bus.in_dst;
      end
      case (state)
        IDLE:    state <= accept ? WR_LO : IDLE;
        WR_LO:   state <= mul_q ? WR_HI : (accept ? WR_LO : IDLE);
        WR_HI:   state <= accept ? WR_LO : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode from state and latched result only; s0/s1 never reach wr_data directly.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    done    = 1'b0;
    case (state)
      WR_LO: begin
        wr_en   = 1'b1;
        wr_addr = dst_q;
        wr_data = lo_q;
        done    = !mul_q;
      end
      WR_HI: begin
        wr_en   = 1'b1;
        wr_addr = dst_q + ADDR_W'(1);
        wr_data = hi_q;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

`ifdef WB_OVF_FLAG_EN
  logic [LANES-1:0] ovf_next;

  wb_ovf_detect u_ovf (
    .lo   (bus.s0),
    .hi   (bus.s1),
    .mask (ovf_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_mask <= '0;
    end else if (accept) begin
      ovf_mask <= bus.in_mul ? ovf_next : '0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_writeback_seq.sv
// Directed bench for alu_writeback_seq; inputs change on the falling edge, outputs are sampled there too.
module tb_alu_writeback_seq;
  import vec_pkg::*;

  logic              clk;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [VW-1:0]     wr_data;
  logic              done;
  logic              busy;
`ifdef WB_OVF_FLAG_EN
  logic [LANES-1:0]  ovf_mask;
`endif

  int n_cmp;
  int n_bad;

  alu_writeback_seq_if bus ();

  alu_writeback_seq dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .done    (done),
    .busy    (busy)
`ifdef WB_OVF_FLAG_EN
    ,
    .ovf_mask(ovf_mask)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [VW-1:0] fill(input logic [LANE_W-1:0] v);
    return {LANES{v}};
  endfunction

  // {wr_en, wr_addr, done, busy, in_ready}
  function automatic logic [5:0] ctl();
    return {wr_en, wr_addr, done, busy, bus.in_ready};
  endfunction

  task automatic drive(input logic v, input logic m, input logic [ADDR_W-1:0] d,
                       input logic [VW-1:0] a, input logic [VW-1:0] b);
    bus.in_valid = v;
    bus.in_mul   = m;
    bus.in_dst   = d;
    bus.s0       = a;
    bus.s1       = b;
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0);
    #3;
    exp = 6'b0_00_0_0_1;
    n_cmp++; if (ctl() !== exp) begin n_bad++; $display("FAIL reset_ctl got %b want %b", ctl(), exp); end
    n_cmp++; if (wr_data !== '0) begin n_bad++; $display("FAIL reset_data got %h want 0", wr_data); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_add();
    logic [5:0] exp;
    drive(1'b1, 1'b0, 2'd2, fill(32'h5), '0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    exp = 6'b1_10_1_1_1;
    n_cmp++; if (ctl() !== exp) begin n_bad++; $display("FAIL add_ctl got %b want %b", ctl(), exp); end
    n_cmp++; if (wr_data !== fill(32'h5)) begin n_bad++; $display("FAIL add_data got %h want %h", wr_data, fill(32'h5)); end
    @(negedge clk);
    exp = 6'b0_00_0_0_1;
    n_cmp++; if (ctl() !== exp) begin n_bad++; $display("FAIL add_idle got %b want %b", ctl(), exp); end
  endtask

  task automatic test_multiply(input logic [ADDR_W-1:0] dst, input logic [ADDR_W-1:0] hi_addr,
                               input logic [LANE_W-1:0] lo, input logic [LANE_W-1:0] hi);
    logic [5:0] exp;
    drive(1'b1, 1'b1, dst, fill(lo), fill(hi));
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    exp = {1'b1, dst, 1'b0, 1'b1, 1'b0};
    n_cmp++; if (ctl() !== exp) begin n_bad++; $display("FAIL mul_lo_ctl dst=%0d got %b want %b", dst, ctl(), exp); end
    n_cmp++; if (wr_data !== fill(lo)) begin n_bad++; $display("FAIL mul_lo_data got %h want %h", wr_data, fill(lo)); end
`ifdef WB_OVF_FLAG_EN
    n_cmp++; if (ovf_mask !== 16'h0000) begin n_bad++; $display("FAIL mul_ovf got %h want 0000", ovf_mask); end
`endif
    @(negedge clk);
    exp = {1'b1, hi_addr, 1'b1, 1'b1, 1'b1};
    n_cmp++; if (ctl() !== exp) begin n_bad++; $display("FAIL mul_hi_ctl dst=%0d got %b want %b", dst, ctl(), exp); end
    n_cmp++; if (wr_data !== fill(hi)) begin n_bad++; $display("FAIL mul_hi_data got %h want %h", wr_data, fill(hi)); end
    @(negedge clk);
    exp = 6'b0_00_0_0_1;
    n_cmp++; if (ctl() !== exp) begin n_bad++; $display("FAIL mul_idle got %b want %b", ctl(), exp); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp;
    drive(1'b1, 1'b0, 2'd0, fill(32'd10), '0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      exp = {1'b1, 2'(i), 1'b1, 1'b1, 1'b1};
      n_cmp++; if (ctl() !== exp) begin n_bad++; $display("FAIL b2b_add%0d_ctl got %b want %b", i, ctl(), exp); end
      n_cmp++; if (wr_data !== fill(32'd10 + 32'(i))) begin n_bad++; $display("FAIL b2b_add%0d_data got %h want %h", i, wr_data, fill(32'd10 + 32'(i))); end
      if (i < 2) drive(1'b1, 1'b0, 2'(i + 1), fill(32'd11 + 32'(i)), '0);
      else       drive(1'b1, 1'b1, 2'd1, fill(32'd20), fill(32'd21));
    end
    @(posedge clk);
    @(negedge clk);
    exp = 6'b1_01_0_1_0;
    n_cmp++; if (ctl() !== exp) begin n_bad++; $display("FAIL b2b_mul_lo_ctl got %b want %b", ctl(), exp); end
    n_cmp++; if (wr_data !== fill(32'd20)) begin n_bad++; $display("FAIL b2b_mul_lo_data got %h want %h", wr_data, fill(32'd20)); end
    // Upstream holds an add while the multiply low beat stalls it.
    drive(1'b1, 1'b0, 2'd3, fill(32'd7), '0);
    @(posedge clk);
    @(negedge clk);
    exp = 6'b1_10_1_1_1;
    n_cmp++; if (ctl() !== exp) begin n_bad++; $display("FAIL b2b_mul_hi_ctl got %b want %b", ctl(), exp); end
    n_cmp++; if (wr_data !== fill(32'd21)) begin n_bad++; $display("FAIL b2b_mul_hi_data got %h want %h", wr_data, fill(32'd21)); end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    exp = 6'b1_11_1_1_1;
    n_cmp++; if (ctl() !== exp) begin n_bad++; $display("FAIL b2b_held_ctl got %b want %b", ctl(), exp); end
    n_cmp++; if (wr_data !== fill(32'd7)) begin n_bad++; $display("FAIL b2b_held_data got %h want %h", wr_data, fill(32'd7)); end
    @(negedge clk);
    exp = 6'b0_00_0_0_1;
    n_cmp++; if (ctl() !== exp) begin n_bad++; $display("FAIL b2b_idle got %b want %b", ctl(), exp); end
  endtask

  task automatic test_reset_midop();
    logic [5:0] exp;
    drive(1'b1, 1'b1, 2'd0, fill(32'h11), fill(32'h22));
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    exp = 6'b1_00_0_1_0;
    n_cmp++; if (ctl() !== exp) begin n_bad++; $display("FAIL rstmid_lo_ctl got %b want %b", ctl(), exp); end
    #1 rst = 1'b1;
    #1;
    exp = 6'b0_00_0_0_1;
    n_cmp++; if (ctl() !== exp) begin n_bad++; $display("FAIL rstmid_async_ctl got %b want %b", ctl(), exp); end
    n_cmp++; if (wr_data !== '0) begin n_bad++; $display("FAIL rstmid_async_data got %h want 0", wr_data); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (wr_en !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_hi%0d got en=%b busy=%b want 0 0", i, wr_en, busy); end
    end
  endtask

`ifdef WB_OVF_FLAG_EN
  task automatic test_ovf();
    logic [VW-1:0] lo;
    logic [VW-1:0] hi;
    lo = fill(32'h2);
    hi = '0;
    lo[LANE_W-1:0] = 32'h0;
    hi[LANE_W-1:0] = 32'h1;
    drive(1'b1, 1'b1, 2'd0, lo, hi);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_cmp++; if (ovf_mask !== 16'h0001) begin n_bad++; $display("FAIL ovf_mul got %h want 0001", ovf_mask); end
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (ovf_mask !== 16'h0001) begin n_bad++; $display("FAIL ovf_hold got %h want 0001", ovf_mask); end
    drive(1'b1, 1'b0, 2'd0, lo, hi);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_cmp++; if (ovf_mask !== 16'h0000) begin n_bad++; $display("FAIL ovf_add got %h want 0000", ovf_mask); end
    @(negedge clk);
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single_add();
    test_multiply(2'd1, 2'd2, 32'hFFFF_FFFA, 32'hFFFF_FFFF);
    test_multiply(2'd3, 2'd0, 32'h0000_1234, 32'h0000_0000);
    test_back_to_back();
    test_reset_midop();
`ifdef WB_OVF_FLAG_EN
    test_ovf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
